// File: rtl/rdma_req_pkt_split.sv
// Splits one RDMA message request into MTU-sized packet descriptors with the RC opcode resolved per packet.
// A read request always yields a single descriptor; unsupported opcodes are accepted, flagged and dropped.
//
// state | meaning
// IDLE  | ready for a request; may still be presenting a single or last descriptor
// SPLIT | presenting a non-last descriptor; the next one is loaded on each handshake
module rdma_req_pkt_split #(
  parameter int PMTU_BYTES = 4096,
  parameter int LEN_W      = 32,
  parameter int VADDR_W    = 64,
  parameter int QPN_W      = 16,
  parameter int MSN_W      = 24
) (
  input  logic               aclk,
  input  logic               rst,
  input  logic               s_req_valid,
  output logic               s_req_ready,
  input  logic [4:0]         s_req_opcode,
  input  logic [QPN_W-1:0]   s_req_qpn,
  input  logic [VADDR_W-1:0] s_req_vaddr,
  input  logic [LEN_W-1:0]   s_req_len,
  input  logic [MSN_W-1:0]   s_req_ssn,
  output logic               m_pkt_valid,
  input  logic               m_pkt_ready,
  output logic [4:0]         m_pkt_opcode,
  output logic [QPN_W-1:0]   m_pkt_qpn,
  output logic [MSN_W-1:0]   m_pkt_ssn,
  output logic [VADDR_W-1:0] m_pkt_vaddr,
  output logic [LEN_W-1:0]   m_pkt_len,
  output logic [MSN_W-1:0]   m_pkt_idx,
  output logic               m_pkt_first,
  output logic               m_pkt_last,
  output logic               err_unsup
);

  localparam logic [LEN_W-1:0]   PMTU_LEN = LEN_W'(PMTU_BYTES);
  localparam logic [VADDR_W-1:0] PMTU_VA  = VADDR_W'(PMTU_BYTES);

  typedef enum logic {IDLE, SPLIT} state_t;
  typedef enum logic [2:0] {CLS_SEND, CLS_WRITE, CLS_RESP, CLS_READ, CLS_BAD} cls_t;

  state_t             state_q, state_d;
  cls_t               cls_q, req_cls, src_cls;
  logic [LEN_W-1:0]   rem_q, src_rem, pkt_len;
  logic [VADDR_W-1:0] vaddr_q, src_vaddr;
  logic [MSN_W-1:0]   idx_q, src_idx;
  logic               accept, advance, load;
  logic               pkt_first, pkt_last;
  logic [4:0]         pkt_opcode;

  assign s_req_ready = (state_q == IDLE) && (!m_pkt_valid || m_pkt_ready);
  assign accept      = s_req_valid && s_req_ready;
  assign advance     = (state_q == SPLIT) && m_pkt_valid && m_pkt_ready;

  always_comb begin
    case (s_req_opcode)
      5'h04:   req_cls = CLS_SEND;
      5'h0A:   req_cls = CLS_WRITE;
      5'h0C:   req_cls = CLS_READ;
      5'h10:   req_cls = CLS_RESP;
      default: req_cls = CLS_BAD;
    endcase
  end

  // Descriptor source: the incoming request on accept, otherwise the running split registers.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    src_cls   = cls_q;
    src_rem   = rem_q;
    src_vaddr = vaddr_q;
    src_idx   = idx_q;
    if (accept) begin
      src_cls   = req_cls;
      src_rem   = s_req_len;
      src_vaddr = s_req_vaddr;
      src_idx   = '0;
      load      = (req_cls != CLS_BAD);
    end
    if (advance) load = 1'b1;

    pkt_last  = (src_rem <= PMTU_LEN);
    pkt_first = (src_idx == '0);
    pkt_len   = pkt_last ? src_rem : PMTU_LEN;
    if (src_cls == CLS_READ) begin
      pkt_last  = 1'b1;
      pkt_first = 1'b1;
      pkt_len   = src_rem;
    end

    case (src_cls)
      CLS_SEND:  pkt_opcode = (pkt_first && pkt_last) ? 5'h04 : pkt_first ? 5'h00 : pkt_last ? 5'h02 : 5'h01;
      CLS_WRITE: pkt_opcode = (pkt_first && pkt_last) ? 5'h0A : pkt_first ? 5'h06 : pkt_last ? 5'h08 : 5'h07;
      CLS_RESP:  pkt_opcode = (pkt_first && pkt_last) ? 5'h10 : pkt_first ? 5'h0D : pkt_last ? 5'h0F : 5'h0E;
      CLS_READ:  pkt_opcode = 5'h0C;
      default:   pkt_opcode = 5'h00;
    endcase

    if (load) state_d = pkt_last ? IDLE : SPLIT;
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q      <= IDLE;
      cls_q        <= CLS_SEND;
      rem_q        <= '0;
      vaddr_q      <= '0;
      idx_q        <= '0;
      m_pkt_valid  <= 1'b0;
      m_pkt_opcode <= '0;
      m_pkt_qpn    <= '0;
      m_pkt_ssn    <= '0;
      m_pkt_vaddr  <= '0;
      m_pkt_len    <= '0;
      m_pkt_idx    <= '0;
      m_pkt_first  <= 1'b0;
      m_pkt_last   <= 1'b0;
      err_unsup    <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_unsup <= accept && (req_cls == CLS_BAD);
      if (load) begin
        m_pkt_valid  <= 1'b1;
        m_pkt_opcode <= pkt_opcode;
        m_pkt_vaddr  <= src_vaddr;
        m_pkt_len    <= pkt_len;
        m_pkt_idx    <= src_idx;
        m_pkt_first  <= pkt_first;
        m_pkt_last   <= pkt_last;
        if (accept) begin
          m_pkt_qpn <= s_req_qpn;
          m_pkt_ssn <= s_req_ssn;
        end
        // Pre-advance to the next packet; values are don't-care once the last one is loaded.
        cls_q   <= src_cls;
        rem_q   <= src_rem - PMTU_LEN;
        vaddr_q <= src_vaddr + PMTU_VA;
        idx_q   <= src_idx + MSN_W'(1);
      end else if (m_pkt_ready) begin
        m_pkt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rdma_req_pkt_split.sv
// Self-checking bench for rdma_req_pkt_split: directed and randomized messages against a
// behavioural packetisation model, with handshake monitoring for stalls and back-to-back flow.
module tb_rdma_req_pkt_split;

  localparam int PMTU = 4096;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [15:0] qpn;
    logic [23:0] ssn;
    logic [63:0] vaddr;
    logic [31:0] len;
    logic [23:0] idx;
    logic        first;
    logic        last;
  } desc_t;

  logic        aclk, rst;
  logic        s_req_valid, s_req_ready;
  logic [4:0]  s_req_opcode;
  logic [15:0] s_req_qpn;
  logic [63:0] s_req_vaddr;
  logic [31:0] s_req_len;
  logic [23:0] s_req_ssn;
  logic        m_pkt_valid, m_pkt_ready;
  logic [4:0]  m_pkt_opcode;
  logic [15:0] m_pkt_qpn;
  logic [23:0] m_pkt_ssn;
  logic [63:0] m_pkt_vaddr;
  logic [31:0] m_pkt_len;
  logic [23:0] m_pkt_idx;
  logic        m_pkt_first, m_pkt_last, err_unsup;

  int     total = 0;
  int     bad   = 0;
  desc_t  got[$];
  desc_t  exp_q[$];
  longint hs_cyc[$];
  longint cyc = 0;
  int     rdy_mode = 0;
  bit     sready_chk = 0;
  int     n_taken = 0;

  rdma_req_pkt_split #(
    .PMTU_BYTES(PMTU), .LEN_W(32), .VADDR_W(64), .QPN_W(16), .MSN_W(24)
  ) dut (
    .aclk(aclk), .rst(rst),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_req_opcode(s_req_opcode), .s_req_qpn(s_req_qpn), .s_req_vaddr(s_req_vaddr),
    .s_req_len(s_req_len), .s_req_ssn(s_req_ssn),
    .m_pkt_valid(m_pkt_valid), .m_pkt_ready(m_pkt_ready),
    .m_pkt_opcode(m_pkt_opcode), .m_pkt_qpn(m_pkt_qpn), .m_pkt_ssn(m_pkt_ssn),
    .m_pkt_vaddr(m_pkt_vaddr), .m_pkt_len(m_pkt_len), .m_pkt_idx(m_pkt_idx),
    .m_pkt_first(m_pkt_first), .m_pkt_last(m_pkt_last), .err_unsup(err_unsup)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  initial forever begin
    @(posedge aclk);
    #1;
    case (rdy_mode)
      0:       m_pkt_ready = 1'b1;
      1:       m_pkt_ready = 1'($urandom_range(0, 1));
      default: m_pkt_ready = 1'b0;
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic desc_t cur_desc();
    desc_t d;
    d.opcode = m_pkt_opcode;
    d.qpn    = m_pkt_qpn;
    d.ssn    = m_pkt_ssn;
    d.vaddr  = m_pkt_vaddr;
    d.len    = m_pkt_len;
    d.idx    = m_pkt_idx;
    d.first  = m_pkt_first;
    d.last   = m_pkt_last;
    return d;
  endfunction

  // Monitor: collects handshakes, checks hold-during-stall and request readiness during backpressure.
  initial begin
    desc_t d, prev_d;
    bit    prev_stall, exp_r;
    prev_stall = 0;
    prev_d     = '0;
    forever begin
      @(negedge aclk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        d = cur_desc();
        if (prev_stall) begin
          total++;
          if (!m_pkt_valid || d !== prev_d) begin
            bad++;
            $display("FAIL stall_hold: got valid=%0b desc=%h, required valid=1 desc=%h", m_pkt_valid, d, prev_d);
          end
        end
        if (sready_chk) begin
          exp_r = (n_taken == 4) && m_pkt_ready;
          total++;
          if (s_req_ready !== exp_r) begin
            bad++;
            $display("FAIL sready_busy: taken=%0d got=%0b required=%0b", n_taken, s_req_ready, exp_r);
          end
        end
        if (m_pkt_valid && m_pkt_ready) begin
          got.push_back(d);
          hs_cyc.push_back(cyc);
          if (sready_chk) begin
            n_taken++;
            if (n_taken == 5) sready_chk = 0;
          end
        end
        prev_stall = m_pkt_valid && !m_pkt_ready;
        prev_d     = d;
      end
    end
  end

  // Reference model: message -> list of packets by plain ceiling division over the MTU.
  task automatic model_push(input logic [4:0] op, input logic [15:0] qpn, input logic [63:0] va,
                            input logic [31:0] len, input logic [23:0] ssn);
    logic [4:0] f, m, l, o;
    longint     n;
    desc_t      d;
    case (op)
      5'h04:   begin f = 5'h00; m = 5'h01; l = 5'h02; o = 5'h04; end
      5'h0A:   begin f = 5'h06; m = 5'h07; l = 5'h08; o = 5'h0A; end
      5'h10:   begin f = 5'h0D; m = 5'h0E; l = 5'h0F; o = 5'h10; end
      default: begin f = 5'h00; m = 5'h00; l = 5'h00; o = 5'h00; end
    endcase
    d.qpn = qpn;
    d.ssn = ssn;
    if (op == 5'h0C) begin
      d.opcode = 5'h0C; d.vaddr = va; d.len = len; d.idx = '0; d.first = 1; d.last = 1;
      exp_q.push_back(d);
    end else if (op == 5'h04 || op == 5'h0A || op == 5'h10) begin
      n = (len == 0) ? 1 : (longint'(len) + PMTU - 1) / PMTU;
      for (longint k = 0; k < n; k++) begin
        d.first  = (k == 0);
        d.last   = (k == n - 1);
        d.len    = d.last ? 32'(longint'(len) - k * PMTU) : 32'(PMTU);
        d.vaddr  = va + 64'(k * PMTU);
        d.idx    = 24'(k);
        d.opcode = (d.first && d.last) ? o : d.first ? f : d.last ? l : m;
        exp_q.push_back(d);
      end
    end
  endtask

  task automatic issue_req(input logic [4:0] op, input logic [15:0] qpn, input logic [63:0] va,
                           input logic [31:0] len, input logic [23:0] ssn);
    bit acc;
    model_push(op, qpn, va, len, ssn);
    s_req_opcode = op;
    s_req_qpn    = qpn;
    s_req_vaddr  = va;
    s_req_len    = len;
    s_req_ssn    = ssn;
    s_req_valid  = 1'b1;
    acc = 0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge aclk);
      acc = s_req_ready;
      @(posedge aclk);
      #1;
    end
    s_req_valid = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL req_accept: op=%h got accepted=0 required=1", op);
    end
  endtask

  task automatic wait_pkts(input int n, output bit ok);
    for (int i = 0; i < 400 && got.size() < n; i++) begin
      @(posedge aclk);
      #1;
    end
    ok = (got.size() >= n);
    repeat (3) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic clear_q();
    got.delete();
    exp_q.delete();
    hs_cyc.delete();
  endtask

  task automatic test_reset();
    @(negedge aclk);
    total++;
    if (m_pkt_valid !== 1'b0 || err_unsup !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: got valid=%0b err=%0b required 0 0", m_pkt_valid, err_unsup);
    end
    total++;
    if (s_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got=%0b required=1", s_req_ready);
    end
    total++;
    if (cur_desc() !== desc_t'(0)) begin
      bad++;
      $display("FAIL reset_data: got=%h required=0", cur_desc());
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_multi_write();
    bit ok;
    clear_q();
    rdy_mode = 0;
    issue_req(5'h0A, 16'(($urandom)), 64'h1000, 32'd10000, 24'($urandom));
    wait_pkts(3, ok);
    total++;
    if (!ok || got.size() != 3 || exp_q.size() != 3) begin
      bad++;
      $display("FAIL write_count: got=%0d required=3", got.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL write_pkt%0d: got=%h required=%h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mtu_boundary();
    bit ok;
    clear_q();
    issue_req(5'h04, 16'($urandom), {$urandom, $urandom}, 32'd4096, 24'($urandom));
    issue_req(5'h04, 16'($urandom), {$urandom, $urandom}, 32'd4097, 24'($urandom));
    wait_pkts(3, ok);
    total++;
    if (!ok || got.size() != exp_q.size()) begin
      bad++;
      $display("FAIL mtu_count: got=%0d required=%0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL mtu_pkt%0d: got=%h required=%h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_and_read();
    bit ok;
    clear_q();
    issue_req(5'h0A, 16'($urandom), {$urandom, $urandom}, 32'd0, 24'($urandom));
    issue_req(5'h0C, 16'($urandom), {$urandom, $urandom}, 32'h100000, 24'($urandom));
    issue_req(5'h10, 16'($urandom), {$urandom, $urandom}, 32'd8192, 24'($urandom));
    wait_pkts(4, ok);
    total++;
    if (!ok || got.size() != exp_q.size()) begin
      bad++;
      $display("FAIL zr_count: got=%0d required=%0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL zr_pkt%0d: got=%h required=%h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_q();
    rdy_mode = 1;
    issue_req(5'h0A, 16'($urandom), {$urandom, $urandom}, 32'(4 * PMTU + $urandom_range(1, PMTU)), 24'($urandom));
    n_taken    = 0;
    sready_chk = 1;
    wait_pkts(5, ok);
    sready_chk = 0;
    rdy_mode   = 0;
    total++;
    if (!ok || got.size() != 5 || exp_q.size() != 5) begin
      bad++;
      $display("FAIL bp_count: got=%0d required=5", got.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL bp_pkt%0d: got=%h required=%h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit gap;
    clear_q();
    rdy_mode = 0;
    issue_req(5'h04, 16'($urandom), {$urandom, $urandom}, 32'(PMTU + $urandom_range(1, PMTU)), 24'($urandom));
    issue_req(5'h10, 16'($urandom), {$urandom, $urandom}, 32'(PMTU + $urandom_range(1, PMTU)), 24'($urandom));
    wait_pkts(4, ok);
    total++;
    if (!ok || got.size() != 4 || exp_q.size() != 4) begin
      bad++;
      $display("FAIL b2b_count: got=%0d required=4", got.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b_pkt%0d: got=%h required=%h", i, got[i], exp_q[i]);
      end
    end
    gap = 0;
    for (int i = 0; i + 1 < hs_cyc.size(); i++)
      if (hs_cyc[i+1] - hs_cyc[i] != 1) gap = 1;
    total++;
    if (gap || hs_cyc.size() != 4) begin
      bad++;
      $display("FAIL b2b_gap: got gap=%0b handshakes=%0d required gap=0 handshakes=4", gap, hs_cyc.size());
    end
  endtask

  task automatic test_unsup();
    int pulses;
    clear_q();
    issue_req(5'h11, 16'($urandom), {$urandom, $urandom}, 32'($urandom_range(0, 3 * PMTU)), 24'($urandom));
    @(negedge aclk);
    total++;
    if (err_unsup !== 1'b1) begin
      bad++;
      $display("FAIL unsup_pulse: got=%0b required=1", err_unsup);
    end
    pulses = 0;
    repeat (6) begin
      @(negedge aclk);
      if (err_unsup) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL unsup_width: extra high cycles got=%0d required=0", pulses);
    end
    total++;
    if (got.size() != 0) begin
      bad++;
      $display("FAIL unsup_nodesc: got=%0d descriptors required=0", got.size());
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    clear_q();
    rdy_mode = 0;
    issue_req(5'h0A, 16'($urandom), {$urandom, $urandom}, 32'(3 * PMTU + $urandom_range(1, PMTU)), 24'($urandom));
    for (int i = 0; i < 100 && got.size() < 2; i++) begin
      @(posedge aclk);
      #1;
    end
    rst = 1'b1;
    @(posedge aclk);
    #1;
    rst = 1'b0;
    @(negedge aclk);
    total++;
    if (m_pkt_valid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_valid: got=%0b required=0", m_pkt_valid);
    end
    seen = 0;
    repeat (8) begin
      @(negedge aclk);
      if (m_pkt_valid) seen = 1;
    end
    total++;
    if (seen || got.size() != 2) begin
      bad++;
      $display("FAIL rstmid_quiet: got valid_seen=%0b pkts=%0d required 0 2", seen, got.size());
    end
    for (int i = 0; i < got.size() && i < 2; i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rstmid_pkt%0d: got=%h required=%h", i, got[i], exp_q[i]);
      end
    end
    @(posedge aclk);
    #1;
    clear_q();
    issue_req(5'h04, 16'($urandom), {$urandom, $urandom}, 32'(PMTU + $urandom_range(1, PMTU)), 24'($urandom));
    wait_pkts(2, ok);
    total++;
    if (!ok || got.size() != 2 || exp_q.size() != 2) begin
      bad++;
      $display("FAIL rstmid_next_count: got=%0d required=2", got.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rstmid_next_pkt%0d: got=%h required=%h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bit         ok;
    logic [4:0] ops[4];
    logic [4:0] op;
    logic [31:0] len;
    logic [63:0] va;
    ops[0] = 5'h04; ops[1] = 5'h0A; ops[2] = 5'h0C; ops[3] = 5'h10;
    clear_q();
    rdy_mode = 1;
    for (int m = 0; m < 8; m++) begin
      op = ops[$urandom_range(0, 3)];
      case ($urandom_range(0, 3))
        0:       len = 32'(PMTU * $urandom_range(1, 3));
        1:       len = 32'(PMTU * $urandom_range(1, 3) + 1);
        2:       len = 32'(PMTU * $urandom_range(1, 3) - 1);
        default: len = 32'($urandom_range(0, 3 * PMTU + 200));
      endcase
      va = (m == 3) ? 64'hFFFF_FFFF_FFFF_F800 : {$urandom, $urandom};
      issue_req(op, 16'($urandom), va, len, 24'($urandom));
    end
    wait_pkts(exp_q.size(), ok);
    rdy_mode = 0;
    total++;
    if (!ok || got.size() != exp_q.size()) begin
      bad++;
      $display("FAIL rand_count: got=%0d required=%0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rand_pkt%0d: got=%h required=%h", i, got[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    s_req_valid  = 1'b0;
    s_req_opcode = '0;
    s_req_qpn    = '0;
    s_req_vaddr  = '0;
    s_req_len    = '0;
    s_req_ssn    = '0;
    m_pkt_ready  = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    rst = 1'b0;
    test_reset();
    test_multi_write();
    test_mtu_boundary();
    test_zero_and_read();
    test_backpressure();
    test_back_to_back();
    test_unsup();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
